posit_encoder_pipe: RTL and testbench

- Pipelined, fully parametrised posit encoder. Packs unpacked fields (sign, regime k, exponent, fraction, sticky, special flags) into an N-bit posit with round-to-nearest-even (RNE), saturation and zero/NaR handling.
- Sits at the tail of the arithmetic datapath, after normalisation and ahead of result writeback.
- Ready/valid on both sides; 2-stage pipeline with full backpressure.

---
 rtl/posit_encoder_pipe.sv | 197 +++++++++++++++++++
 tb/tb_posit_encoder_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_encoder_pipe.sv
// posit_encoder_pipe: packs unpacked posit fields (sign, regime k, exponent,
// fraction, sticky, zero/NaR flags) into an N-bit posit.
// Stage S1 assembles the regime/exponent/fraction string and extracts
// body/guard/sticky, deciding saturation. Stage S2 applies round-to-nearest-even,
// clamps to maxpos/minpos, applies the sign and resolves specials.
// Ready/valid on both sides with full backpressure; two beats of storage.
module posit_encoder_pipe #(
   parameter int N      = 8,
   parameter int ES     = 1,
   parameter int FRAC_W = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_sign,
   input  logic [7:0]                    in_regime,
   input  logic [((ES > 0) ? ES : 1)-1:0] in_exponent,
   input  logic [FRAC_W-1:0]             in_frac,
   input  logic                          in_sticky,
   input  logic                          in_zero,
   input  logic                          in_nar,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [N-1:0]                  out_posit
);

   // Tail = exponent then fraction; the extended string leaves room for the
   // longest non-saturating regime run (N-1 bits) above the tail.
   localparam int TW     = ES + FRAC_W;
   localparam int XW     = TW + N;
   localparam int SAT_HI = N - 2;
   localparam int SAT_LO = -(N - 1);

   localparam logic [XW-1:0]  ALL_ONES    = {XW{1'b1}};
   localparam logic [XW-1:0]  TOP_ONE     = {1'b1, {(XW-1){1'b0}}};
   localparam logic [N-2:0]   MAXPOS_BODY = {(N-1){1'b1}};
   localparam logic [N-2:0]   MINPOS_BODY = {{(N-2){1'b0}}, 1'b1};
   localparam logic [N-1:0]   NAR_POSIT   = {1'b1, {(N-1){1'b0}}};
   localparam logic [N-1:0]   ZERO_POSIT  = {N{1'b0}};

   // Handshake
   logic s1_valid_r;
   logic s2_valid_r;
   logic s1_advance_s;

   // S1 combinational
   logic [TW-1:0]        tail_s;
   logic signed [31:0]   k_s;
   logic [31:0]          run_len_s;
   logic [31:0]          ones_shift_s;
   logic [31:0]          neg_k_s;
   logic [XW-1:0]        regime_s;
   logic [XW-1:0]        ext_s;
   logic                 sat_hi_s;
   logic                 sat_lo_s;
   logic [N-2:0]         body_s;
   logic                 guard_s;
   logic                 sticky_s;

   // S1 registers
   logic                 s1_sign_r;
   logic [N-2:0]         s1_body_r;
   logic                 s1_guard_r;
   logic                 s1_sticky_r;
   logic                 s1_sat_hi_r;
   logic                 s1_sat_lo_r;
   logic                 s1_zero_r;
   logic                 s1_nar_r;

   // S2 combinational
   logic                 inc_s;
   logic [N-1:0]         sum_s;
   logic [N-2:0]         body_fin_s;
   logic [N-1:0]         mag_s;
   logic [N-1:0]         enc_s;

   // S2 / output register
   logic [N-1:0]         out_posit_r;

   assign s1_advance_s = ~s2_valid_r | out_ready;
   assign in_ready     = ~s1_valid_r | s1_advance_s;
   assign out_valid    = s2_valid_r;
   assign out_posit    = out_posit_r;

   assign k_s = {{24{in_regime[7]}}, in_regime};

   generate
      if (ES > 0) begin : g_exp
         assign tail_s = {in_exponent, in_frac};
      end else begin : g_noexp
         assign tail_s = in_frac;
      end
   endgenerate

   // Build the extended body string: regime run on top, tail shifted below it.
   always_comb begin
      run_len_s    = 32'd0;
      ones_shift_s = 32'd0;
      neg_k_s      = 32'd0;
      regime_s     = {XW{1'b0}};
      if (k_s >= 32'sd0) begin
         run_len_s    = k_s + 32'sd2;
         ones_shift_s = k_s + 32'sd1;
         regime_s     = ~(ALL_ONES >> ones_shift_s);
      end else begin
         neg_k_s      = -k_s;
         run_len_s    = 32'sd1 - k_s;
         regime_s     = TOP_ONE >> neg_k_s;
      end
      ext_s = ({tail_s, {N{1'b0}}} >> run_len_s) | regime_s;
   end

   // Extract body/guard/sticky and override the body when the regime saturates.
   always_comb begin
      sat_hi_s = (k_s >= SAT_HI);
      sat_lo_s = (k_s <= SAT_LO);
      body_s   = ext_s[XW-1 -: N-1];
      guard_s  = ext_s[XW-N];
      sticky_s = (|ext_s[XW-N-1:0]) | in_sticky;
      if (sat_hi_s) begin
         body_s   = MAXPOS_BODY;
         guard_s  = 1'b0;
         sticky_s = 1'b0;
      end else if (sat_lo_s) begin
         body_s   = MINPOS_BODY;
         guard_s  = 1'b0;
         sticky_s = 1'b0;
      end else begin
         body_s   = ext_s[XW-1 -: N-1];
      end
   end

   // S1 register: loads a new beat whenever the stage is empty or draining.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r  <= 1'b0;
         s1_sign_r   <= 1'b0;
         s1_body_r   <= {(N-1){1'b0}};
         s1_guard_r  <= 1'b0;
         s1_sticky_r <= 1'b0;
         s1_sat_hi_r <= 1'b0;
         s1_sat_lo_r <= 1'b0;
         s1_zero_r   <= 1'b0;
         s1_nar_r    <= 1'b0;
      end else if (in_ready) begin
         s1_valid_r <= in_valid;
         if (in_valid) begin
            s1_sign_r   <= in_sign;
            s1_body_r   <= body_s;
            s1_guard_r  <= guard_s;
            s1_sticky_r <= sticky_s;
            s1_sat_hi_r <= sat_hi_s;
            s1_sat_lo_r <= sat_lo_s;
            s1_zero_r   <= in_zero;
            s1_nar_r    <= in_nar;
         end
      end
   end

   // Round to nearest even, clamp to maxpos/minpos, apply sign and specials.
   always_comb begin
      inc_s = s1_guard_r & (s1_body_r[0] | s1_sticky_r) & ~s1_sat_hi_r & ~s1_sat_lo_r;
      sum_s = {1'b0, s1_body_r} + {{(N-1){1'b0}}, inc_s};
      if (sum_s[N-1]) begin
         body_fin_s = MAXPOS_BODY;
      end else if (sum_s[N-2:0] == {(N-1){1'b0}}) begin
         body_fin_s = MINPOS_BODY;
      end else begin
         body_fin_s = sum_s[N-2:0];
      end
      mag_s = {1'b0, body_fin_s};
      if (s1_nar_r) begin
         enc_s = NAR_POSIT;
      end else if (s1_zero_r) begin
         enc_s = ZERO_POSIT;
      end else if (s1_sign_r) begin
         enc_s = ~mag_s + {{(N-1){1'b0}}, 1'b1};
      end else begin
         enc_s = mag_s;
      end
   end

   // Output register: holds while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_r  <= 1'b0;
         out_posit_r <= {N{1'b0}};
      end else if (s1_advance_s) begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            out_posit_r <= enc_s;
         end
      end
   end

endmodule

// File: tb/tb_posit_encoder_pipe.sv
// Self-checking bench for posit_encoder_pipe (N=8, ES=1, FRAC_W=8).
// Reference model builds the posit bit string as a queue of bits and rounds
// with integer arithmetic.
module tb_posit_encoder_pipe;
   localparam int N      = 8;
   localparam int ES     = 1;
   localparam int FRAC_W = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic       in_sign;
   logic [7:0] in_regime;
   logic [0:0] in_exponent;
   logic [7:0] in_frac;
   logic       in_sticky;
   logic       in_zero;
   logic       in_nar;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_posit;

   int checks = 0;
   int errors = 0;
   int nacc   = 0;
   int nrecv  = 0;
   logic [7:0] sb[$];

   always #5 clk = ~clk;

   posit_encoder_pipe #(.N(N), .ES(ES), .FRAC_W(FRAC_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_regime(in_regime), .in_exponent(in_exponent),
      .in_frac(in_frac), .in_sticky(in_sticky), .in_zero(in_zero), .in_nar(in_nar),
      .out_valid(out_valid), .out_ready(out_ready), .out_posit(out_posit)
   );

   // Reference: regime run, exponent, fraction as a bit list; RNE on integers.
   function automatic logic [7:0] ref_enc(input bit s, input int k, input int e, input int f,
                                          input bit st, input bit z, input bit nr);
      bit q[$];
      int body;
      int g;
      int stk;
      if (nr) return 8'h80;
      if (z) return 8'h00;
      if (k >= N - 2) begin
         body = 127;
      end else if (k <= -(N - 1)) begin
         body = 1;
      end else begin
         if (k >= 0) begin
            for (int i = 0; i < k + 1; i++) q.push_back(1'b1);
            q.push_back(1'b0);
         end else begin
            for (int i = 0; i < -k; i++) q.push_back(1'b0);
            q.push_back(1'b1);
         end
         q.push_back(e[0]);
         for (int i = 7; i >= 0; i--) q.push_back(f[i]);
         body = 0;
         for (int i = 0; i < N - 1; i++) body = body * 2 + int'(q[i]);
         g = int'(q[N-1]);
         stk = int'(st);
         for (int i = N; i < q.size(); i++) stk = stk | int'(q[i]);
         if (g == 1 && ((body % 2) == 1 || stk == 1)) body = body + 1;
         if (body > 127) body = 127;
         if (body == 0) body = 1;
      end
      if (s) body = 256 - body;
      return body[7:0];
   endfunction

   task automatic set_fields(input bit s, input int k, input int e, input int f,
                             input bit st, input bit z, input bit nr);
      in_sign     = s;
      in_regime   = k[7:0];
      in_exponent = e[0:0];
      in_frac     = f[7:0];
      in_sticky   = st;
      in_zero     = z;
      in_nar      = nr;
   endtask

   // One clock with scoreboard bookkeeping; entered and left at edge+1.
   task automatic tick();
      logic [7:0] e;
      bit         held;
      logic [7:0] held_v;
      #1;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         nrecv++;
         checks++;
         assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_out: got %h, expected no output", out_posit);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            assert (out_posit === e) else begin
               errors++;
               $error("FAIL data: got %h expected %h", out_posit, e);
            end
         end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
         nacc++;
         sb.push_back(ref_enc(in_sign, int'($signed(in_regime)), int'(in_exponent),
                              int'(in_frac), in_sticky, in_zero, in_nar));
      end
      held   = (out_valid === 1'b1) && (out_ready === 1'b0);
      held_v = out_posit;
      @(posedge clk);
      #1;
      if (held) begin
         checks++;
         assert (out_valid === 1'b1 && out_posit === held_v) else begin
            errors++;
            $error("FAIL stall_hold: got v=%b p=%h expected v=1 p=%h", out_valid, out_posit, held_v);
         end
      end
   endtask

   // Single beat with latency check against a constant from the plan.
   task automatic directed(input string tag, input bit s, input int k, input int e, input int f,
                           input bit st, input bit z, input bit nr, input logic [7:0] exp);
      set_fields(s, k, e, f, st, z, nr);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++;
      assert (out_valid === 1'b0) else begin
         errors++;
         $error("FAIL %s_early: out_valid=%b expected 0", tag, out_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      assert (out_valid === 1'b1 && out_posit === exp) else begin
         errors++;
         $error("FAIL %s: got v=%b p=%h expected v=1 p=%h", tag, out_valid, out_posit, exp);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int bp_k[6];
      int bp_f[6];
      int idx;
      int a0;
      int k;
      bp_k = '{-3, -1, 0, 1, 2, 4};
      bp_f = '{8'h11, 8'h22, 8'h5A, 8'h80, 8'hC3, 8'h0F};

      // Reset
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      set_fields(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checks++;
      assert (out_valid === 1'b0 && out_posit === 8'h00 && in_ready === 1'b1) else begin
         errors++;
         $error("FAIL reset: got v=%b p=%h rdy=%b expected v=0 p=00 rdy=1", out_valid, out_posit, in_ready);
      end
      @(posedge clk);
      #1;

      // Basic encode, rounding, saturation and specials
      directed("basic_pos",  1'b0,   0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h40);
      directed("basic_frac", 1'b0,   0, 0, 8'h80, 1'b0, 1'b0, 1'b0, 8'h48);
      directed("basic_neg",  1'b1,   0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hC0);
      directed("rne_tie0",   1'b0,   0, 0, 8'h08, 1'b0, 1'b0, 1'b0, 8'h40);
      directed("rne_tie1",   1'b0,   0, 0, 8'h18, 1'b0, 1'b0, 1'b0, 8'h42);
      directed("rne_up",     1'b0,   0, 0, 8'h09, 1'b0, 1'b0, 1'b0, 8'h41);
      directed("sticky_only",1'b0,   0, 0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h40);
      directed("sat_hi",     1'b0,   7, 0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h7F);
      directed("sat_hi_neg", 1'b1,   7, 0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h81);
      directed("sat_lo",     1'b0, -10, 0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01);
      directed("nar",        1'b1,   3, 1, 8'h55, 1'b0, 1'b1, 1'b1, 8'h80);
      directed("zero_neg",   1'b1,   2, 1, 8'hAA, 1'b0, 1'b1, 1'b0, 8'h00);
      directed("no_wrap",    1'b0,   5, 1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h7F);

      // Backpressure: six beats, consumer stalled for the first three cycles
      sb.delete();
      nacc  = 0;
      nrecv = 0;
      idx   = 0;
      for (int c = 0; c < 40 && nrecv < 6; c++) begin
         if (idx < 6) begin
            set_fields(1'b0, bp_k[idx], idx % 2, bp_f[idx], 1'b0, 1'b0, 1'b0);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         out_ready = (c >= 3);
         if (c == 2) begin
            #1;
            checks++;
            assert (in_ready === 1'b0) else begin
               errors++;
               $error("FAIL bp_in_ready: got %b expected 0", in_ready);
            end
         end
         a0 = nacc;
         tick();
         if (nacc != a0) idx++;
      end
      in_valid = 1'b0;
      checks++;
      assert (nrecv === 6 && sb.size() === 0) else begin
         errors++;
         $error("FAIL bp_count: got recv=%0d pending=%0d expected recv=6 pending=0", nrecv, sb.size());
      end

      // Reset with two beats in flight
      out_ready = 1'b0;
      set_fields(1'b0, 1, 1, 8'h33, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1;
      tick();
      set_fields(1'b1, -2, 0, 8'h44, 1'b0, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      #1;
      checks++;
      assert (out_valid === 1'b0 && in_ready === 1'b1) else begin
         errors++;
         $error("FAIL flush: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
      end
      out_ready = 1'b1;
      repeat (4) tick();

      // Random sweep
      nacc  = 0;
      nrecv = 0;
      for (int c = 0; c < 60000; c++) begin
         if (nacc < 10000) begin
            k = int'($urandom_range(0, 22)) - 11;
            if ($urandom_range(0, 15) == 0) k = int'($urandom_range(0, 255)) - 128;
            set_fields(1'($urandom_range(0, 1)), k, int'($urandom_range(0, 1)),
                       int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
         end else begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
         end
         tick();
         if (nacc >= 10000 && sb.size() == 0 && out_valid === 1'b0) break;
      end
      checks++;
      assert (nacc === 10000 && nrecv === 10000 && sb.size() === 0) else begin
         errors++;
         $error("FAIL random_count: got acc=%0d recv=%0d pending=%0d expected 10000/10000/0",
                nacc, nrecv, sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
